// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: segment polarity,
// the hex-to-segment table and the digit index width helper.
package seg7_pkg;

    // Cathode byte with every segment and the decimal point dark.
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    // Anodes are active low: 0 enables a digit.
    localparam logic       ANODE_ON  = 1'b0;
    localparam logic       ANODE_OFF = 1'b1;

    // Width needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to seven-segment decoder, active-high outputs.
// Polarity inversion for the board is applied in the scanner's output register.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Look up the segment pattern for the selected nibble.
    always_comb begin
        seg_o = hex_to_seg7(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner. A loaded word is held in a shadow
// buffer and swapped into the displayed (active) buffer at frame boundaries.
// Each digit slot is split into 2**BR_W PWM phases; phase 0 is dead time so
// the previous digit's cathodes never ghost onto the next anode.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS = 8,
    parameter int unsigned N_GROUPS = 2,
    parameter int unsigned SCAN_DIV = 3125,
    parameter int unsigned BR_W     = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic [4*N_DIGITS-1:0]              value,
    input  logic [N_DIGITS-1:0]                dp_mask,
    input  logic [N_DIGITS-1:0]                blank_mask,
    input  logic [BR_W-1:0]                    bright,
    input  logic                               hold,
    output logic [N_DIGITS-1:0]                anode,
    output logic [8*N_GROUPS-1:0]              cathode,
    output logic [idx_width(N_DIGITS)-1:0]     cur_digit,
    output logic                               frame_start
);

    localparam int unsigned IDX_W          = idx_width(N_DIGITS);
    localparam int unsigned GRP_W          = idx_width(N_GROUPS);
    localparam int unsigned PRESC_W        = idx_width(SCAN_DIV);
    localparam int unsigned DIGITS_PER_GRP = N_DIGITS / N_GROUPS;
    localparam logic [BR_W-1:0]    PHASE_MAX  = {BR_W{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   DIGIT_LAST = IDX_W'(N_DIGITS - 1);

    // Scan counters
    logic [PRESC_W-1:0]      presc_q,  presc_d;
    logic [BR_W-1:0]         phase_q,  phase_d;
    logic [IDX_W-1:0]        digit_q,  digit_d;

    // Shadow (written by load) and active (displayed) buffers
    logic [4*N_DIGITS-1:0]   shadow_val_q,   shadow_val_d;
    logic [N_DIGITS-1:0]     shadow_dp_q,    shadow_dp_d;
    logic [N_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
    logic [4*N_DIGITS-1:0]   active_val_q,   active_val_d;
    logic [N_DIGITS-1:0]     active_dp_q,    active_dp_d;
    logic [N_DIGITS-1:0]     active_blank_q, active_blank_d;
    logic                    pending_q,      pending_d;

    // Registered pin drivers
    logic [N_DIGITS-1:0]     anode_q,       anode_d;
    logic [8*N_GROUPS-1:0]   cathode_q,     cathode_d;
    logic                    frame_start_q, frame_start_d;

    // Combinational helpers
    logic                    tick_s;
    logic                    slot_end_s;
    logic                    wrap_s;
    logic [3:0]              nibble_s;
    logic                    dp_s;
    logic                    blank_s;
    logic                    enable_s;
    logic [GRP_W-1:0]        grp_s;
    logic [6:0]              seg_s;

    seg7_hex_decode u_decode (
        .nibble_i (nibble_s),
        .seg_o    (seg_s)
    );

    // Prescaler tick, end of digit slot and end of frame detection.
    always_comb begin
        tick_s     = (presc_q == PRESC_LAST);
        slot_end_s = tick_s && (phase_q == PHASE_MAX);
        wrap_s     = slot_end_s && (digit_q == DIGIT_LAST);
    end

    // Next-state for prescaler, PWM phase and digit index.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        digit_d = digit_q;
        if (tick_s) begin
            presc_d = {PRESC_W{1'b0}};
            phase_d = phase_q + BR_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
        if (slot_end_s) begin
            if (digit_q == DIGIT_LAST) begin
                digit_d = {IDX_W{1'b0}};
            end else begin
                digit_d = digit_q + IDX_W'(1);
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Shadow capture, frame-boundary swap and pending bookkeeping.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        active_val_d   = active_val_q;
        active_dp_d    = active_dp_q;
        active_blank_d = active_blank_q;
        pending_d      = pending_q;
        if (hold) begin
            // Display frozen: ignore loads, keep any pending swap for later.
            pending_d = pending_q;
        end else if (load && wrap_s) begin
            // Load on the boundary itself goes straight to the display.
            shadow_val_d   = value;
            shadow_dp_d    = dp_mask;
            shadow_blank_d = blank_mask;
            active_val_d   = value;
            active_dp_d    = dp_mask;
            active_blank_d = blank_mask;
            pending_d      = 1'b0;
        end else if (load) begin
            shadow_val_d   = value;
            shadow_dp_d    = dp_mask;
            shadow_blank_d = blank_mask;
            pending_d      = 1'b1;
        end else if (wrap_s && pending_q) begin
            active_val_d   = shadow_val_q;
            active_dp_d    = shadow_dp_q;
            active_blank_d = shadow_blank_q;
            pending_d      = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Select the current digit's data and decide whether it is lit this phase.
    always_comb begin
        nibble_s = active_val_q[int'(digit_q)*4 +: 4];
        dp_s     = active_dp_q[digit_q];
        blank_s  = active_blank_q[digit_q];
        grp_s    = GRP_W'(int'(digit_q) / int'(DIGITS_PER_GRP));
        enable_s = (phase_q != {BR_W{1'b0}}) && (phase_q <= bright) && !blank_s;
    end

    // Build next anode/cathode pin values; only the lit digit's bank is driven.
    always_comb begin
        anode_d       = {N_DIGITS{ANODE_OFF}};
        cathode_d     = {N_GROUPS{SEG_OFF}};
        frame_start_d = wrap_s;
        if (enable_s) begin
            anode_d[digit_q]               = ANODE_ON;
            cathode_d[int'(grp_s)*8 +: 8]  = ~{dp_s, seg_s};
        end else begin
            anode_d   = {N_DIGITS{ANODE_OFF}};
            cathode_d = {N_GROUPS{SEG_OFF}};
        end
    end

    // State and output registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= {PRESC_W{1'b0}};
            phase_q        <= {BR_W{1'b0}};
            digit_q        <= {IDX_W{1'b0}};
            shadow_val_q   <= {(4*N_DIGITS){1'b0}};
            shadow_dp_q    <= {N_DIGITS{1'b0}};
            shadow_blank_q <= {N_DIGITS{1'b1}};
            active_val_q   <= {(4*N_DIGITS){1'b0}};
            active_dp_q    <= {N_DIGITS{1'b0}};
            active_blank_q <= {N_DIGITS{1'b1}};
            pending_q      <= 1'b0;
            anode_q        <= {N_DIGITS{ANODE_OFF}};
            cathode_q      <= {N_GROUPS{SEG_OFF}};
            frame_start_q  <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            phase_q        <= phase_d;
            digit_q        <= digit_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            active_val_q   <= active_val_d;
            active_dp_q    <= active_dp_d;
            active_blank_q <= active_blank_d;
            pending_q      <= pending_d;
            anode_q        <= anode_d;
            cathode_q      <= cathode_d;
            frame_start_q  <= frame_start_d;
        end
    end

    // Drive ports from registers.
    always_comb begin
        anode       = anode_q;
        cathode     = cathode_q;
        cur_digit   = digit_q;
        frame_start = frame_start_q;
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 2 banks, 8-cycle slots.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [1:0]  bright;
    logic        hold;
    logic [3:0]  anode;
    logic [15:0] cathode;
    logic [1:0]  cur_digit;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .N_DIGITS (4),
        .N_GROUPS (2),
        .SCAN_DIV (2),
        .BR_W     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .bright      (bright),
        .hold        (hold),
        .anode       (anode),
        .cathode     (cathode),
        .cur_digit   (cur_digit),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where frame_start is high (bounded).
    task automatic wait_frame(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_start && cyc < 70);
        if (!frame_start) chk({tag, "_timeout"}, 32'(frame_start), 32'd1);
    endtask

    // Observe one full frame (32 samples) starting at a frame_start negedge.
    // exp_cath holds the expected cathode byte for digit d in bits [8d+7:8d].
    task automatic scan(input string tag, input logic [31:0] exp_cath,
                        input int on_cnt, input logic [3:0] blank);
        int on [4];
        int overlap;
        int cbad;
        int fsbad;
        int nz;
        int d;
        logic [15:0] exp16;
        for (int j = 0; j < 4; j++) on[j] = 0;
        overlap = 0;
        cbad    = 0;
        fsbad   = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            load = 1'b0;
            nz = 0;
            d  = 0;
            for (int j = 0; j < 4; j++) begin
                if (anode[j] == 1'b0) begin
                    nz++;
                    d = j;
                end
            end
            if (nz > 1) overlap++;
            exp16 = 16'hFFFF;
            if (nz == 1) begin
                on[d]++;
                exp16[(d/2)*8 +: 8] = exp_cath[d*8 +: 8];
            end
            if (cathode !== exp16) cbad++;
            if (frame_start !== (k == 32)) fsbad++;
        end
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s_on%0d", tag, j), 32'(on[j]), blank[j] ? 32'd0 : 32'(on_cnt));
        chk({tag, "_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_cathode"}, 32'(cbad), 32'd0);
        chk({tag, "_fstart"}, 32'(fsbad), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = 16'h0000;
        dp_mask    = 4'b0000;
        blank_mask = 4'b0000;
        bright     = 2'd3;
        hold       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_cathode", 32'(cathode), 32'hFFFF);
        chk("rst_digit", 32'(cur_digit), 32'd0);
        chk("rst_fstart", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        // No load yet: dark display, frame_start every 32 cycles.
        wait_frame("fs0", n);
        chk("first_frame", 32'(n), 32'd32);
        wait_frame("fs1", n);
        chk("frame_period", 32'(n), 32'd32);
        scan("dark", 32'h0, 6, 4'hF);

        // Load 3210 with dp on digit 2; visible from the next frame.
        value = 16'h3210; dp_mask = 4'b0100; blank_mask = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame("fs2", n);
        scan("hex3210", 32'hB024_F9C0, 6, 4'b0000);

        // Brightness changes take effect without restarting the slot.
        bright = 2'd1;
        scan("br1", 32'hB024_F9C0, 2, 4'b0000);
        bright = 2'd0;
        scan("br0", 32'hB024_F9C0, 0, 4'b0000);
        bright = 2'd3;

        // Mid-frame load: old contents until the boundary, then all F.
        value = 16'hFFFF; dp_mask = 4'b0000; load = 1'b1;
        scan("preF", 32'hB024_F9C0, 6, 4'b0000);
        scan("allF", 32'h8E8E_8E8E, 6, 4'b0000);

        // Hold: load ignored for three frames.
        hold = 1'b1; value = 16'h1111; load = 1'b1;
        scan("hold0", 32'h8E8E_8E8E, 6, 4'b0000);
        scan("hold1", 32'h8E8E_8E8E, 6, 4'b0000);
        scan("hold2", 32'h8E8E_8E8E, 6, 4'b0000);

        // Release hold and load on the boundary cycle itself.
        hold = 1'b0;
        repeat (31) @(negedge clk);
        value = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_fstart", 32'(frame_start), 32'd1);
        scan("bnd2222", 32'hA4A4_A4A4, 6, 4'b0000);

        // Blank digits 1 and 3.
        blank_mask = 4'b1010; load = 1'b1;
        scan("preblank", 32'hA4A4_A4A4, 6, 4'b0000);
        scan("blank", 32'hA4A4_A4A4, 6, 4'b1010);

        // Reset in the middle of a lit phase: outputs go dark immediately.
        repeat (3) @(negedge clk);
        chk("prerst_anode", 32'(anode), 32'hE);
        chk("prerst_cathode", 32'(cathode), 32'hFFA4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_anode", 32'(anode), 32'hF);
        chk("midrst_cathode", 32'(cathode), 32'hFFFF);
        chk("midrst_digit", 32'(cur_digit), 32'd0);
        chk("midrst_fstart", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame("fs3", n);
        chk("postrst_frame", 32'(n), 32'd32);
        scan("postrst", 32'h0, 6, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
